// File: rtl/uart_tx_fifo_if.sv
// Byte-stream bundle between the user logic, the TX FIFO and UartTx.
// The master side drives bytes in and reports the transmitter's readiness.
interface uart_tx_fifo_if #(
    parameter int DEPTH_LOG = 4
);
    logic [7:0]         WDATA;
    logic               WE;
    logic               FULL;
    logic               EMPTY;
    logic [DEPTH_LOG:0] COUNT;
    logic               OVERFLOW;
    logic               OVF_CLR;
    logic [7:0]         TX_DATA;
    logic               TX_WE;
    logic               TX_READY;

    modport master (
        output WDATA, WE, OVF_CLR, TX_READY,
        input  FULL, EMPTY, COUNT, OVERFLOW, TX_DATA, TX_WE
    );

    modport slave (
        input  WDATA, WE, OVF_CLR, TX_READY,
        output FULL, EMPTY, COUNT, OVERFLOW, TX_DATA, TX_WE
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding UartTx: absorbs bursts and issues one-cycle TX_WE strobes,
// spaced by a hold window, whenever the transmitter reports ready.
module uart_tx_fifo #(
    parameter int DEPTH_LOG = 4,
    parameter int HOLD_CYC  = 2
) (
    input  logic            CLK,
    input  logic            RST,
    uart_tx_fifo_if.slave   bus
);
    localparam int DEPTH = 2 ** DEPTH_LOG;
    localparam int HW    = $clog2(HOLD_CYC + 1);

    typedef enum logic [1:0] {IDLE, HOLD, WAIT} state_t;

    state_t               state_q, state_d;
    logic [HW-1:0]        hold_q, hold_d;
    logic                 tx_we_q, tx_we_d;
    logic [7:0]           tx_data_q;
    logic [7:0]           mem [DEPTH];
    logic [DEPTH_LOG-1:0] wp_q, rp_q;
    logic [DEPTH_LOG:0]   count_q;
    logic                 ovf_q;
    logic                 full, empty, wr_ok, deq;

    // Flags come from the pre-edge count, so a dequeue never frees room for a same-edge write.
    assign full  = (count_q == (DEPTH_LOG + 1)'(DEPTH));
    assign empty = (count_q == '0);
    assign wr_ok = bus.WE && !full;

    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        tx_we_d = 1'b0;
        deq     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!empty && bus.TX_READY) begin
                    deq     = 1'b1;
                    tx_we_d = 1'b1;
                    hold_d  = HW'(HOLD_CYC);
                    state_d = HOLD;
                end
            end
            HOLD: begin
                hold_d = hold_q - 1'b1;
                if (hold_q == HW'(1)) state_d = WAIT;
            end
            WAIT: begin
                if (bus.TX_READY) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            hold_q  <= '0;
            tx_we_q <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            tx_we_q <= tx_we_d;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wp_q      <= '0;
            rp_q      <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            tx_data_q <= '0;
        end else begin
            if (wr_ok) wp_q <= wp_q + 1'b1;
            if (deq) begin
                rp_q      <= rp_q + 1'b1;
                tx_data_q <= mem[rp_q];
            end
            unique case ({wr_ok, deq})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            // A dropped write beats a simultaneous clear so an error is never lost.
            if (bus.WE && full)  ovf_q <= 1'b1;
            else if (bus.OVF_CLR) ovf_q <= 1'b0;
        end
    end

    // NOTE: the storage array is deliberately not reset; the pointers and count define validity.
    always_ff @(posedge CLK) begin
        if (wr_ok) mem[wp_q] <= bus.WDATA;
    end

    assign bus.FULL     = full;
    assign bus.EMPTY    = empty;
    assign bus.COUNT    = count_q;
    assign bus.OVERFLOW = ovf_q;
    assign bus.TX_DATA  = tx_data_q;
    assign bus.TX_WE    = tx_we_q;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: queue-based reference model compared every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_uart_tx_fifo;
    localparam int DEPTH_LOG = 4;
    localparam int DEPTH     = 16;
    localparam int HOLD_CYC  = 2;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    uart_tx_fifo_if #(.DEPTH_LOG(DEPTH_LOG)) bus ();

    uart_tx_fifo #(.DEPTH_LOG(DEPTH_LOG), .HOLD_CYC(HOLD_CYC)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a byte queue plus "cycles since last issue" timing.
    logic [7:0] mq[$];
    bit         m_ovf, m_we, m_armed, m_full, m_issue;
    logic [7:0] m_data;
    int         m_cyc, m_last;

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            mq.delete();
            m_ovf = 0; m_we = 0; m_data = 8'h00; m_armed = 1; m_cyc = 0; m_last = 0;
        end else begin
            m_cyc++;
            m_full  = (mq.size() == DEPTH);
            m_issue = m_armed && bus.TX_READY && (mq.size() > 0);
            if (m_issue) begin
                m_data  = mq.pop_front();
                m_we    = 1;
                m_last  = m_cyc;
                m_armed = 0;
            end else begin
                m_we = 0;
                if (!m_armed && bus.TX_READY && m_cyc >= m_last + HOLD_CYC + 1) m_armed = 1;
            end
            if (bus.WE && !m_full) mq.push_back(bus.WDATA);
            if (bus.WE && m_full) m_ovf = 1;
            else if (bus.OVF_CLR) m_ovf = 0;
        end
    end

    always @(negedge CLK) begin
        check("count",    32'(bus.COUNT),    32'(mq.size()));
        check("full",     32'(bus.FULL),     32'(mq.size() == DEPTH));
        check("empty",    32'(bus.EMPTY),    32'(mq.size() == 0));
        check("overflow", 32'(bus.OVERFLOW), 32'(m_ovf));
        check("tx_we",    32'(bus.TX_WE),    32'(m_we));
        check("tx_data",  32'(bus.TX_DATA),  32'(m_data));
    end

    task automatic cycle(input bit we, input logic [7:0] d, input bit rdy, input bit clr);
        bus.WE = we; bus.WDATA = d; bus.TX_READY = rdy; bus.OVF_CLR = clr;
        @(negedge CLK);
        #1;
    endtask

    task automatic pulse_reset();
        RST = 1'b1;
        @(negedge CLK); #1;
        RST = 1'b0;
    endtask

    logic [7:0] got[$];
    int         busy;
    int         pulses;
    bit         rdy;

    initial begin
        bus.WE = 0; bus.WDATA = 8'h00; bus.TX_READY = 0; bus.OVF_CLR = 0;
        repeat (2) @(negedge CLK);
        #1;
        check("rst_count", 32'(bus.COUNT), 32'd0);
        check("rst_empty", 32'(bus.EMPTY), 32'd1);
        check("rst_tx_we", 32'(bus.TX_WE), 32'd0);
        RST = 1'b0;

        // Single byte: strobe one cycle after the write edge, FIFO empty again.
        cycle(1, 8'h61, 1, 0);
        check("t1_count1", 32'(bus.COUNT), 32'd1);
        check("t1_no_we",  32'(bus.TX_WE), 32'd0);
        cycle(0, 8'h00, 1, 0);
        check("t1_we",     32'(bus.TX_WE),   32'd1);
        check("t1_data",   32'(bus.TX_DATA), 32'h61);
        check("t1_count0", 32'(bus.COUNT),   32'd0);
        check("t1_empty",  32'(bus.EMPTY),   32'd1);
        cycle(0, 8'h00, 0, 0);
        check("t1_we_off", 32'(bus.TX_WE),   32'd0);

        // Fill to full with the transmitter busy, then overflow and clear.
        for (int i = 0; i < DEPTH; i++) cycle(1, 8'(8'h61 + i), 0, 0);
        check("t2_full",  32'(bus.FULL),  32'd1);
        check("t2_count", 32'(bus.COUNT), 32'd16);
        cycle(1, 8'h71, 0, 0);
        check("t2_ovf",    32'(bus.OVERFLOW), 32'd1);
        check("t2_count2", 32'(bus.COUNT),    32'd16);
        cycle(0, 8'h00, 0, 1);
        check("t2_ovf_clr", 32'(bus.OVERFLOW), 32'd0);

        // Drain through a transmitter that stays busy 10 cycles per byte.
        busy = 0;
        for (int i = 0; i < 600 && got.size() < DEPTH; i++) begin
            rdy = (busy == 0);
            cycle(0, 8'h00, rdy, 0);
            if (bus.TX_WE) begin
                got.push_back(bus.TX_DATA);
                busy = 10;
            end else if (busy > 0) begin
                busy--;
            end
        end
        check("t3_drained", 32'(got.size()), 32'd16);
        foreach (got[i]) check("t3_order", 32'(got[i]), 32'(8'h61 + i));
        check("t3_empty", 32'(bus.EMPTY), 32'd1);

        // Full FIFO, write coinciding with a dequeue is still dropped.
        repeat (10) cycle(0, 8'h00, 1, 0);
        for (int i = 0; i < DEPTH; i++) cycle(1, 8'(8'hA0 + i), 0, 0);
        cycle(1, 8'hEE, 1, 0);
        check("t4_count", 32'(bus.COUNT),    32'd15);
        check("t4_ovf",   32'(bus.OVERFLOW), 32'd1);
        check("t4_we",    32'(bus.TX_WE),    32'd1);
        check("t4_data",  32'(bus.TX_DATA),  32'hA0);

        // Reset while five bytes are held and the strobe hold window is active.
        pulse_reset();
        for (int i = 0; i < 6; i++) cycle(1, 8'(8'h30 + i), 0, 0);
        cycle(0, 8'h00, 1, 0);
        check("t5_we",    32'(bus.TX_WE), 32'd1);
        check("t5_count", 32'(bus.COUNT), 32'd5);
        cycle(0, 8'h00, 0, 0);
        RST = 1'b1;
        #1;
        check("t5_rst_count", 32'(bus.COUNT),    32'd0);
        check("t5_rst_empty", 32'(bus.EMPTY),    32'd1);
        check("t5_rst_we",    32'(bus.TX_WE),    32'd0);
        check("t5_rst_data",  32'(bus.TX_DATA),  32'd0);
        check("t5_rst_ovf",   32'(bus.OVERFLOW), 32'd0);
        @(negedge CLK); #1;
        RST = 1'b0;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            cycle(0, 8'h00, 1, 0);
            pulses += int'(bus.TX_WE);
        end
        check("t5_no_we", 32'(pulses), 32'd0);

        // Randomized traffic, checked every cycle against the model.
        busy = 0;
        for (int i = 0; i < 3000; i++) begin
            rdy = (busy == 0) && ($urandom_range(0, 9) != 0);
            cycle($urandom_range(0, 99) < 55, 8'($urandom), rdy, $urandom_range(0, 19) == 0);
            if (bus.TX_WE) busy = $urandom_range(0, 12);
            else if (busy > 0) busy--;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
